// File: rtl/student_parity_rx.sv
// rtl/student_parity_rx.sv - serial start/data/parity/stop frame receiver with parity check
module student_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shift_reg;
    logic               run_par;
    logic               perr;
    logic               slot_free;

    // The output slot can take a new word if empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);

    // Frame FSM, shift register and registered output slot with handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_reg  <= '0;
            run_par    <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Acceptance drains the slot; a same-edge load below overrides it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            cnt     <= '0;
                            run_par <= (PARITY_ODD != 0);
                        end
                    end
                    DATA: begin
                        shift_reg[cnt] <= serial_in;
                        run_par        <= run_par ^ serial_in;
                        if (cnt == LAST_BIT) begin
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        // Seeded with PARITY_ODD, so any nonzero result is a mismatch.
                        perr  <= run_par ^ serial_in;
                        state <= STOP;
                    end
                    STOP: begin
                        if (slot_free) begin
                            data_out   <= shift_reg;
                            parity_err <= perr;
                            frame_err  <= ~serial_in;
                            out_valid  <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        // A 0 stop bit is not a start bit: always go back and wait.
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/student_parity_rx.md
Name: student_parity_rx

Overview:
- Serial frame receiver with parity check. It is the receiving end of the team's XOR-based parity generator/transmitter path.
- Deserialises start/data/parity/stop frames sampled on an external bit strobe. It recomputes parity over the received data bits and presents each completed word on a valid/ready output port with error flags.
- Sits between the serial line input stage and the word-level consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame (range 1..32).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- bit_en  input  1  sample strobe; serial_in is consumed only in cycles where bit_en=1.
- serial_in  input  1  serial line; idle level 1.
- data_out  output  DATA_W  received word; LSB is the first data bit received.
- out_valid  output  1  data_out and the error flags are valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- parity_err  output  1  parity mismatch for the presented word.
- frame_err  output  1  stop bit was 0 for the presented word.
- overrun  output  1  sticky flag: a completed frame was dropped. Cleared only by reset.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: data_out=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, bit counter=0, shift register=0, running parity=0.
- Frame format, one bit per bit_en cycle: start(0), DATA_W data bits LSB first, parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
- Transitions, taken only in bit_en=1 cycles (bit_en=0 holds all state):
  - IDLE: serial_in=0 -> DATA, with counter=0 and running parity=PARITY_ODD. serial_in=1 -> stay in IDLE.
  - DATA: shift serial_in into bit position counter; parity ^= serial_in. When counter=DATA_W-1 -> PARITY, else counter+1.
  - PARITY: compute perr = parity ^ serial_in (1 = mismatch) -> STOP.
  - STOP: complete the frame (see below) -> IDLE.
- Frame completion, in the STOP bit_en cycle:
  - Computed values: ferr = ~serial_in.
  - If output slot is free (out_valid=0, or out_valid && out_ready in the same cycle): next cycle data_out = shift register, parity_err = perr, frame_err = ferr, out_valid = 1.
  - Otherwise the new frame is discarded and overrun is set to 1. The held word and its flags are unchanged.
- Latency: out_valid rises on the first clk edge after the STOP bit_en cycle, i.e. a 1-cycle registered output.
- Handshake:
  - data_out, parity_err and frame_err stay stable while out_valid && !out_ready.
  - out_valid falls after the acceptance edge, unless a new word loads on that same edge, in which case out_valid stays 1 and the new word is presented.
- Output buffering: the shift register is separate from the output register, so reception continues while a word is held.
- Frame-error word: a word with a frame error is still delivered, with frame_err=1. A 0 stop bit is not treated as a new start bit; the FSM returns to IDLE and waits for the next 0.
- Reset mid-frame: the partial frame is abandoned and all outputs return to reset values on that edge. Reset has priority over bit_en and out_ready.
- out_ready is ignored while out_valid=0.

Test Plan:
- Even parity, DATA_W=8: frame 0,[0xA5 LSB-first],0,1 with out_ready=1 -> data_out=0xA5, out_valid pulses 1 cycle after the stop strobe, parity_err=0, frame_err=0.
- Parity error: byte 0x01 with parity bit 0 (even mode) -> data_out=0x01, parity_err=1. With PARITY_ODD=1, parity bit 0 -> parity_err=0.
- Frame error: byte 0x3C, correct parity, stop bit 0 -> data_out=0x3C, frame_err=1. A following good frame 0x55 -> frame_err=0.
- Back-pressure/overrun: out_ready=0 across two complete frames 0x11 then 0x22 -> data_out remains 0x11, overrun=1. Asserting out_ready -> word accepted, out_valid=0, overrun stays 1.
- Simultaneous accept and load: hold 0x11, assert out_ready in the STOP strobe cycle of 0x22 -> next cycle out_valid=1, data_out=0x22, overrun=0.
- Reset mid-frame plus gapped strobes: bit_en every 3rd cycle; assert reset after 4 data bits -> all outputs 0, busy=0. The next full frame 0x7E decodes correctly.
